feadd_arb: RTL and testbench
============================

FEADD_ARB -- requirements
Module: feadd_arb

Interface
REQ-001 Parameter NREQ, default 4, number of requesters sharing one field adder; legal range 2..8.
REQ-002 clock  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 req  input  NREQ  per-requester request level; held high until the matching gnt pulse.
REQ-005 req_a  input  NREQ*255  packed operand A, slice k belongs to requester k; stable while req[k] is high.
REQ-006 req_b  input  NREQ*255  packed operand B, same slicing and stability rule as req_a.
REQ-007 gnt  output  NREQ  one-hot, one-cycle pulse; operands of that requester captured this cycle.
REQ-008 resp_valid  output  NREQ  one-hot, one-cycle pulse; resp_out is valid for that requester.
REQ-009 resp_id  output  $clog2(NREQ)  index of the requester currently owning the adder; valid with resp_valid.
REQ-010 resp_out  output  255  (a + b) mod (2^255 - 19), fully reduced, held until the next resp_valid.
REQ-011 busy  output  1  high in every state except IDLE.

Function
REQ-012 FSM states: IDLE, ISSUE, WAIT, RESP; exactly one active.
REQ-013 IDLE: if any req bit is high, select the winner by round-robin, pulse gnt[winner], latch req_a/req_b slices and winner index into local registers, go to ISSUE; otherwise stay in IDLE.
REQ-014 Round-robin: search starts at index ptr, wrapping NREQ-1 -> 0; after a grant to k, ptr = (k+1) mod NREQ.
REQ-015 ISSUE: drive feadd start=1 for exactly one cycle with the latched operands, then go to WAIT.
REQ-016 Latched operands stay applied to feadd from ISSUE until RESP; requester inputs are not looked at after gnt.
REQ-017 WAIT: sample feadd done only in WAIT, never in the ISSUE cycle. On done=1, copy feadd out into resp_out and go to RESP.
REQ-018 No timeout: WAIT lasts until done is sampled high.
REQ-019 RESP: pulse resp_valid[owner] for one cycle with resp_id = owner, then go to IDLE.
REQ-020 Throughput: at most one operation in flight; the minimum gap between two gnt pulses is 3 cycles plus the feadd latency.
REQ-021 If req[k] drops before a grant, the request is withdrawn with no response.
REQ-022 A new req from the owner during ISSUE, WAIT or RESP is treated as a fresh request, arbitrated in the next IDLE.
REQ-023 The arbiter never alters operands; a requester that reads its own resp_valid sees the result for the operands presented at its gnt.

Reset
REQ-024 While reset=1 on a rising edge:
  - state = IDLE, ptr = 0;
  - gnt, resp_valid and start = 0; resp_id = 0; resp_out = 0; busy = 0.
REQ-025 Reset during ISSUE or WAIT abandons the operation:
  - no resp_valid is ever issued for it;
  - a stale done from the abandoned operation is ignored, because done is sampled only in WAIT after a new ISSUE.
REQ-026 Reset has priority over every other event in the same cycle.

Structure
REQ-027 Shared package fe_pkg holds:
  - FE_BITS = 255;
  - the prime P = 2^255 - 19;
  - the FSM state enum.
REQ-028 Exactly one sub-module, feadd, instantiated once, with ports (clock, start, a, b, done, out); the arbiter adds no arithmetic of its own.

Verification
REQ-029 Single request: req[0] with a=15, b=7 -> gnt[0] next cycle, then resp_valid[0], resp_id=0, resp_out=22.
REQ-030 Wrap-around: req[2] with a=2^255-20, b=20 -> resp_out=19; with a=2^255-20, b=1 -> resp_out=0.
REQ-031 All four requesting at once after reset, each with a=k, b=1 -> grants in order 0,1,2,3; resp_out 1,2,3,4 on matching resp_valid bits.
REQ-032 Fairness: after a grant to 1, reqs 0 and 2 high together -> requester 2 granted before 0.
REQ-033 Reset mid-operation: reset asserted one cycle in WAIT -> no resp_valid for that operation. Then req[3] with a=b=2^254-1 -> resp_out=17.
REQ-034 Withdrawal: req[1] raised then dropped while requester 0 is served -> no gnt[1] and no resp_valid[1].

Source files
------------

// File: rtl/fe_pkg.sv
// Shared constants and FSM encoding for the field-adder arbiter.
// Field is GF(2^255 - 19); operands are fully reduced 255-bit values.
package fe_pkg;

  localparam int FE_BITS = 255;

  localparam logic [FE_BITS:0] P = (256'd1 << 255) - 256'd19;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_t;

endpackage

// File: rtl/feadd_arb_feadd.sv
// Two-stage modular adder: raw sum, then one conditional subtract of P.
// done pulses two cycles after start; out holds until the next result.
module feadd
  import fe_pkg::*;
(
  input  logic               clock,
  input  logic               start,
  input  logic [FE_BITS-1:0] a,
  input  logic [FE_BITS-1:0] b,
  output logic               done,
  output logic [FE_BITS-1:0] out
);

  logic [FE_BITS:0] sum_q;
  logic             v1;

  // Reduced inputs sum below 2P, so a single subtraction suffices.
  always_ff @(posedge clock) begin
    v1   <= start;
    done <= v1;
    if (start)
      sum_q <= {1'b0, a} + {1'b0, b};
    if (v1)
      out <= (sum_q >= P) ? FE_BITS'(sum_q - P)
                          : sum_q[FE_BITS-1:0];
  end

endmodule

// File: rtl/feadd_arb.sv
// Round-robin arbiter sharing one feadd among NREQ requesters.
// One operation in flight: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
module feadd_arb
  import fe_pkg::*;
#(
  parameter int NREQ = 4
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic [NREQ-1:0]                req,
  input  logic [NREQ*FE_BITS-1:0]        req_a,
  input  logic [NREQ*FE_BITS-1:0]        req_b,
  output logic [NREQ-1:0]                gnt,
  output logic [NREQ-1:0]                resp_valid,
  output logic [$clog2(NREQ)-1:0]        resp_id,
  output logic [FE_BITS-1:0]             resp_out,
  output logic                           busy
);

  localparam int IW = $clog2(NREQ);

  state_t             state, state_nx;
  logic [IW-1:0]      ptr, owner, win;
  logic               hit;
  logic [FE_BITS-1:0] op_a, op_b, sum;
  logic               start, done;

  always_comb begin
    int j;
    j   = 0;
    win = '0;
    hit = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      j = int'(ptr) + i;
      if (j >= NREQ)
        j = j - NREQ;
      if (!hit && req[j]) begin
        hit = 1'b1;
        win = IW'(j);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:  if (hit) state_nx = ISSUE;
      ISSUE: state_nx = WAIT;
      WAIT:  if (done) state_nx = RESP;
      RESP:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Reset masks every pulse in the cycle it is asserted.
  always_comb begin
    gnt        = '0;
    resp_valid = '0;
    start      = 1'b0;
    busy       = 1'b0;
    if (!reset) begin
      busy = (state != IDLE);
      unique case (state)
        IDLE:    if (hit) gnt[win] = 1'b1;
        ISSUE:   start = 1'b1;
        RESP:    resp_valid[owner] = 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      ptr      <= '0;
      owner    <= '0;
      resp_out <= '0;
    end else begin
      if (state == IDLE && hit) begin
        owner <= win;
        op_a  <= req_a[win*FE_BITS +: FE_BITS];
        op_b  <= req_b[win*FE_BITS +: FE_BITS];
        ptr   <= (win == IW'(NREQ-1)) ? '0 : win + IW'(1);
      end
      if (state == WAIT && done)
        resp_out <= sum;
    end
  end

  assign resp_id = owner;

  feadd u_feadd (
    .clock (clock),
    .start (start),
    .a     (op_a),
    .b     (op_b),
    .done  (done),
    .out   (sum)
  );

endmodule

// File: tb/tb_feadd_arb.sv
// Directed bench for feadd_arb: arbitration order, modular results,
// reset abandonment and request withdrawal.
module tb_feadd_arb;

  logic             clock = 1'b0;
  logic             reset;
  logic [3:0]       req;
  logic [4*255-1:0] req_a, req_b;
  logic [3:0]       gnt, resp_valid;
  logic [1:0]       resp_id;
  logic [254:0]     resp_out;
  logic             busy;

  int n_cmp = 0;
  int n_bad = 0;

  feadd_arb #(.NREQ(4)) dut (
    .clock      (clock),
    .reset      (reset),
    .req        (req),
    .req_a      (req_a),
    .req_b      (req_b),
    .gnt        (gnt),
    .resp_valid (resp_valid),
    .resp_id    (resp_id),
    .resp_out   (resp_out),
    .busy       (busy)
  );

  always #5 clock = ~clock;

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic set_op(input int k, input logic [254:0] a,
                        input logic [254:0] b);
    req_a[k*255 +: 255] = a;
    req_b[k*255 +: 255] = b;
  endtask

  task automatic do_reset();
    cyc();
    reset = 1'b1;
    req   = '0;
    cyc();
    reset = 1'b0;
  endtask

  task automatic wait_gnt(output int k, output bit ok);
    ok = 1'b0;
    k  = -1;
    for (int c = 0; c < 20 && !ok; c++) begin
      @(negedge clock);
      if (gnt != 4'b0) begin
        ok = 1'b1;
        for (int i = 0; i < 4; i++)
          if (gnt[i]) k = i;
      end
    end
  endtask

  task automatic wait_resp(output logic [3:0] rv, output logic [1:0] id,
                           output logic [254:0] out, output bit ok);
    ok  = 1'b0;
    rv  = '0;
    id  = '0;
    out = '0;
    for (int c = 0; c < 20 && !ok; c++) begin
      @(negedge clock);
      if (resp_valid != 4'b0) begin
        ok  = 1'b1;
        rv  = resp_valid;
        id  = resp_id;
        out = resp_out;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    req   = 4'b1111;
    req_a = '0;
    req_b = '0;
    cyc();
    cyc();
    @(negedge clock);
    n_cmp++;
    if (gnt !== 4'b0) begin
      n_bad++;
      $display("FAIL reset_gnt: got %b want 0000", gnt);
    end
    n_cmp++;
    if (resp_valid !== 4'b0 || resp_id !== 2'd0) begin
      n_bad++;
      $display("FAIL reset_resp: got rv=%b id=%0d want 0/0",
               resp_valid, resp_id);
    end
    n_cmp++;
    if (resp_out !== 255'd0 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_out_busy: got out=%0h busy=%b want 0/0",
               resp_out, busy);
    end
    cyc();
    req   = '0;
    reset = 1'b0;
  endtask

  task automatic test_single();
    int k; bit ok;
    logic [3:0] rv; logic [1:0] id; logic [254:0] out;
    cyc();
    set_op(0, 255'd15, 255'd7);
    req = 4'b0001;
    wait_gnt(k, ok);
    n_cmp++;
    if (!ok || k != 0) begin
      n_bad++;
      $display("FAIL single_gnt: got ok=%0d k=%0d want 1/0", ok, k);
    end
    cyc();
    req = 4'b0000;
    @(negedge clock);
    n_cmp++;
    if (busy !== 1'b1) begin
      n_bad++;
      $display("FAIL single_busy: got %b want 1", busy);
    end
    wait_resp(rv, id, out, ok);
    n_cmp++;
    if (!ok || rv !== 4'b0001 || id !== 2'd0 || out !== 255'd22) begin
      n_bad++;
      $display("FAIL single_resp: got ok=%0d rv=%b id=%0d out=%0h want 1/0001/0/16",
               ok, rv, id, out);
    end
    @(negedge clock);
    n_cmp++;
    if (resp_valid !== 4'b0 || resp_out !== 255'd22 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL single_hold: got rv=%b out=%0h busy=%b want 0000/16/0",
               resp_valid, resp_out, busy);
    end
  endtask

  task automatic test_wrap();
    int k; bit ok;
    logic [3:0] rv; logic [1:0] id; logic [254:0] out;
    logic [254:0] pm1;
    logic [254:0] bv [2];
    logic [254:0] ev [2];
    pm1 = {255{1'b1}};
    pm1 = pm1 - 255'd19;
    bv[0] = 255'd20; ev[0] = 255'd19;
    bv[1] = 255'd1;  ev[1] = 255'd0;
    for (int n = 0; n < 2; n++) begin
      cyc();
      set_op(2, pm1, bv[n]);
      req = 4'b0100;
      wait_gnt(k, ok);
      n_cmp++;
      if (!ok || k != 2) begin
        n_bad++;
        $display("FAIL wrap_gnt%0d: got ok=%0d k=%0d want 1/2", n, ok, k);
      end
      cyc();
      req = 4'b0000;
      wait_resp(rv, id, out, ok);
      n_cmp++;
      if (!ok || rv !== 4'b0100 || id !== 2'd2 || out !== ev[n]) begin
        n_bad++;
        $display("FAIL wrap_resp%0d: got ok=%0d rv=%b id=%0d out=%0h want 1/0100/2/%0h",
                 n, ok, rv, id, out, ev[n]);
      end
    end
  endtask

  task automatic test_all();
    int k; bit ok;
    logic [3:0] rv; logic [1:0] id; logic [254:0] out;
    do_reset();
    for (int i = 0; i < 4; i++)
      set_op(i, 255'(i), 255'd1);
    req = 4'b1111;
    for (int n = 0; n < 4; n++) begin
      wait_gnt(k, ok);
      n_cmp++;
      if (!ok || k != n) begin
        n_bad++;
        $display("FAIL all_gnt%0d: got ok=%0d k=%0d want 1/%0d", n, ok, k, n);
      end
      cyc();
      if (k >= 0) req[k] = 1'b0;
      wait_resp(rv, id, out, ok);
      n_cmp++;
      if (!ok || rv !== 4'(1 << n) || id !== 2'(n) || out !== 255'(n + 1)) begin
        n_bad++;
        $display("FAIL all_resp%0d: got ok=%0d rv=%b id=%0d out=%0h want rv bit %0d out %0d",
                 n, ok, rv, id, out, n, n + 1);
      end
    end
  endtask

  task automatic test_fairness();
    int k; bit ok;
    int order [3];
    logic [3:0] rv; logic [1:0] id; logic [254:0] out;
    do_reset();
    set_op(0, 255'd100, 255'd1);
    set_op(1, 255'd200, 255'd1);
    set_op(2, 255'd300, 255'd1);
    req = 4'b0010;
    for (int n = 0; n < 3; n++) begin
      wait_gnt(k, ok);
      order[n] = ok ? k : -1;
      cyc();
      if (k >= 0) req[k] = 1'b0;
      if (n == 0) req = req | 4'b0101;
      wait_resp(rv, id, out, ok);
    end
    n_cmp++;
    if (order[0] != 1 || order[1] != 2 || order[2] != 0) begin
      n_bad++;
      $display("FAIL fair_order: got %0d,%0d,%0d want 1,2,0",
               order[0], order[1], order[2]);
    end
    n_cmp++;
    if (out !== 255'd101 || id !== 2'd0) begin
      n_bad++;
      $display("FAIL fair_last: got out=%0d id=%0d want 101/0", out, id);
    end
  endtask

  task automatic test_reset_mid();
    int k; bit ok; bit seen;
    logic [3:0] rv; logic [1:0] id; logic [254:0] out;
    logic [254:0] h;
    cyc();
    set_op(0, 255'd1, 255'd1);
    req = 4'b0001;
    wait_gnt(k, ok);
    cyc();
    req = 4'b0000;
    cyc();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clock);
      if (resp_valid != 4'b0 || busy) seen = 1'b1;
    end
    n_cmp++;
    if (seen) begin
      n_bad++;
      $display("FAIL rstmid_quiet: got resp_valid/busy activity want none");
    end
    h = 255'd1 << 254;
    h = h - 255'd1;
    cyc();
    set_op(3, h, h);
    req = 4'b1000;
    wait_gnt(k, ok);
    n_cmp++;
    if (!ok || k != 3) begin
      n_bad++;
      $display("FAIL rstmid_gnt: got ok=%0d k=%0d want 1/3", ok, k);
    end
    cyc();
    req = 4'b0000;
    wait_resp(rv, id, out, ok);
    n_cmp++;
    if (!ok || rv !== 4'b1000 || id !== 2'd3 || out !== 255'd17) begin
      n_bad++;
      $display("FAIL rstmid_resp: got ok=%0d rv=%b id=%0d out=%0d want 1/1000/3/17",
               ok, rv, id, out);
    end
  endtask

  task automatic test_withdraw();
    int k; bit ok;
    int g1, r1, r0;
    cyc();
    set_op(0, 255'd5, 255'd6);
    set_op(1, 255'd9, 255'd9);
    req = 4'b0001;
    wait_gnt(k, ok);
    n_cmp++;
    if (!ok || k != 0) begin
      n_bad++;
      $display("FAIL wd_gnt0: got ok=%0d k=%0d want 1/0", ok, k);
    end
    cyc();
    req = 4'b0010;
    g1 = 0; r1 = 0; r0 = 0;
    @(negedge clock);
    if (gnt[1]) g1++;
    cyc();
    req = 4'b0000;
    for (int c = 0; c < 12; c++) begin
      @(negedge clock);
      if (gnt[1]) g1++;
      if (resp_valid[1]) r1++;
      if (resp_valid[0]) r0++;
    end
    n_cmp++;
    if (g1 != 0 || r1 != 0) begin
      n_bad++;
      $display("FAIL wd_req1: got gnt1=%0d rv1=%0d want 0/0", g1, r1);
    end
    n_cmp++;
    if (r0 != 1 || resp_out !== 255'd11) begin
      n_bad++;
      $display("FAIL wd_resp0: got count=%0d out=%0d want 1/11", r0, resp_out);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_wrap();
    test_all();
    test_fairness();
    test_reset_mid();
    test_withdraw();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
